// File: rtl/lc3b_types.sv
// Shared LC-3b types: word and cache-line widths plus the memory arbiter state.
// Used by cache_arbiter (optional round-robin via CACHE_ARB_ROUND_ROBIN_EN).
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cache_line;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2
  } lc3b_arb_state;

  // A client asserting both read and write is treated as a write.
  function automatic logic arb_read_cmd(input logic rd, input logic wr);
    return rd & ~wr;
  endfunction

endpackage

// File: rtl/cache_arbiter_control.sv
// Arbiter FSM and grant selection between the I-cache and D-cache clients.
// CACHE_ARB_ROUND_ROBIN_EN selects round-robin contention; otherwise D-cache wins.
module cache_arbiter_control
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic          d_req,
  input  logic          pmem_resp,
  output lc3b_arb_state state
);

  lc3b_arb_state state_q, state_d;
  lc3b_arb_state contend_state;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  // 1 means the D-cache held the most recent grant.
  logic last_d_q, last_d_d;

  always_comb begin
    contend_state = last_d_q ? ARB_SERVE_I : ARB_SERVE_D;
  end
`else
  always_comb begin
    contend_state = ARB_SERVE_D;
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (i_req && d_req) begin
          state_d = contend_state;
        end else if (i_req) begin
          state_d = ARB_SERVE_I;
        end else if (d_req) begin
          state_d = ARB_SERVE_D;
        end
      end
      ARB_SERVE_I, ARB_SERVE_D: begin
        if (pmem_resp) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  always_comb begin
    last_d_d = last_d_q;
    if (state_q == ARB_IDLE && state_d != ARB_IDLE) begin
      last_d_d = (state_d == ARB_SERVE_D);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d_q <= 1'b1;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/cache_arbiter.sv
// Two-client (I-cache / D-cache) physical memory arbiter: output muxing only.
// Define CACHE_ARB_ROUND_ROBIN_EN for round-robin contention, else D-cache priority.
module cache_arbiter
  import lc3b_types::*;
(
  input  logic           clk,
  input  logic           rst,

  input  logic           i_mem_read,
  input  logic           i_mem_write,
  input  lc3b_word       i_mem_address,
  input  lc3b_cache_line i_mem_wdata,
  output lc3b_cache_line i_mem_rdata,
  output logic           i_mem_resp,

  input  logic           d_mem_read,
  input  logic           d_mem_write,
  input  lc3b_word       d_mem_address,
  input  lc3b_cache_line d_mem_wdata,
  output lc3b_cache_line d_mem_rdata,
  output logic           d_mem_resp,

  output logic           pmem_read,
  output logic           pmem_write,
  output lc3b_word       pmem_address,
  output lc3b_cache_line pmem_wdata,
  input  lc3b_cache_line pmem_rdata,
  input  logic           pmem_resp
);

  lc3b_arb_state state;

  cache_arbiter_control u_control (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_mem_read | i_mem_write),
    .d_req     (d_mem_read | d_mem_write),
    .pmem_resp (pmem_resp),
    .state     (state)
  );

  // Commands follow the granted client live, so a dropped request is visible downstream.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_mem_resp   = 1'b0;
    d_mem_resp   = 1'b0;
    unique case (state)
      ARB_SERVE_I: begin
        pmem_read    = arb_read_cmd(i_mem_read, i_mem_write);
        pmem_write   = i_mem_write;
        pmem_address = i_mem_address;
        pmem_wdata   = i_mem_wdata;
        i_mem_resp   = pmem_resp;
      end
      ARB_SERVE_D: begin
        pmem_read    = arb_read_cmd(d_mem_read, d_mem_write);
        pmem_write   = d_mem_write;
        pmem_address = d_mem_address;
        pmem_wdata   = d_mem_wdata;
        d_mem_resp   = pmem_resp;
      end
      default: begin
      end
    endcase
  end

  assign i_mem_rdata = pmem_rdata;
  assign d_mem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed table, corner sequences, random traffic.
module tb_cache_arbiter;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_r = 0, i_w = 0, d_r = 0, d_w = 0;
  logic [15:0] i_a = '0, d_a = '0;
  logic [127:0] i_wd = '0, d_wd = '0;
  logic [127:0] i_mem_rdata, d_mem_rdata;
  logic i_mem_resp, d_mem_resp;
  logic pmem_read, pmem_write;
  logic [15:0] pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] prd = '0;
  logic presp = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cache_arbiter dut (
    .clk(clk), .rst(rst),
    .i_mem_read(i_r), .i_mem_write(i_w), .i_mem_address(i_a), .i_mem_wdata(i_wd),
    .i_mem_rdata(i_mem_rdata), .i_mem_resp(i_mem_resp),
    .d_mem_read(d_r), .d_mem_write(d_w), .d_mem_address(d_a), .d_mem_wdata(d_wd),
    .d_mem_rdata(d_mem_rdata), .d_mem_resp(d_mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(prd), .pmem_resp(presp)
  );

  // Reference model: is a transfer in progress, for whom, and who was granted last.
  bit m_busy = 0;
  bit m_who = 0;      // 0 = I, 1 = D
  bit m_last_d = 1;
  int busy_cnt = 0;

  function automatic logic [147:0] model_out();
    logic pr, pw, ir, dr;
    logic [15:0] a;
    logic [127:0] w;
    pr = 0; pw = 0; ir = 0; dr = 0; a = '0; w = '0;
    if (m_busy && !m_who) begin
      pw = i_w; pr = i_r && !i_w; a = i_a; w = i_wd; ir = presp;
    end else if (m_busy) begin
      pw = d_w; pr = d_r && !d_w; a = d_a; w = d_wd; dr = presp;
    end
    return {pr, pw, a, w, ir, dr};
  endfunction

  function automatic logic [147:0] dut_out();
    return {pmem_read, pmem_write, pmem_address, pmem_wdata, i_mem_resp, d_mem_resp};
  endfunction

  task automatic check_out(input string name);
    logic [147:0] e, g;
    e = model_out();
    g = dut_out();
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s outputs: got=%h want=%h", name, g, e);
    end
    checks++;
    if (i_mem_rdata !== prd || d_mem_rdata !== prd) begin
      errors++;
      $display("FAIL %s rdata: i=%h d=%h want=%h", name, i_mem_rdata, d_mem_rdata, prd);
    end
  endtask

  task automatic model_edge();
    bit ireq, dreq, who;
    ireq = i_r || i_w;
    dreq = d_r || d_w;
    if (m_busy) begin
      if (presp) m_busy = 0;
    end else if (ireq || dreq) begin
      if (ireq && dreq) who = RR ? !m_last_d : 1'b1;
      else who = dreq;
      m_busy = 1; m_who = who; m_last_d = who;
    end
    busy_cnt = m_busy ? busy_cnt + 1 : 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic step(input string name);
    #1;
    check_out(name);
    tick();
  endtask

  task automatic clear_inputs();
    i_r = 0; i_w = 0; d_r = 0; d_w = 0; i_a = '0; d_a = '0;
    i_wd = '0; d_wd = '0; presp = 0; prd = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    m_busy = 0; m_last_d = 1; busy_cnt = 0;
    clear_inputs();
    @(negedge clk);
    rst = 0;
  endtask

  typedef struct {
    logic ir, iw; logic [15:0] ia;
    logic dr, dw; logic [15:0] da; logic [127:0] dwd;
    logic presp; logic [127:0] prd;
    logic epr, epw; logic [15:0] ea; logic [127:0] ewd; logic eir, edr;
  } vec_t;

  function automatic vec_t mk(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                              input logic [15:0] da, input logic [127:0] dwd, input logic rsp,
                              input logic [127:0] rd, input logic epr, input logic epw,
                              input logic [15:0] ea, input logic [127:0] ewd,
                              input logic eir, input logic edr);
    vec_t v;
    v.ir = ir; v.iw = 1'b0; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
    v.presp = rsp; v.prd = rd; v.epr = epr; v.epw = epw; v.ea = ea; v.ewd = ewd;
    v.eir = eir; v.edr = edr;
    return v;
  endfunction

  localparam logic [127:0] LA = {8{16'hAAAA}};
  localparam logic [127:0] L5 = {8{16'h5555}};
  localparam logic [127:0] LC = {8{16'hC3C3}};

  vec_t tbl[$];

  task automatic run_table();
    logic [147:0] e, g;
    for (int k = 0; k < tbl.size(); k++) begin
      i_r = tbl[k].ir; i_w = tbl[k].iw; i_a = tbl[k].ia; i_wd = '0;
      d_r = tbl[k].dr; d_w = tbl[k].dw; d_a = tbl[k].da; d_wd = tbl[k].dwd;
      presp = tbl[k].presp; prd = tbl[k].prd;
      #1;
      e = {tbl[k].epr, tbl[k].epw, tbl[k].ea, tbl[k].ewd, tbl[k].eir, tbl[k].edr};
      g = dut_out();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL table[%0d]: got=%h want=%h", k, g, e);
      end
      check_out($sformatf("table[%0d]", k));
      tick();
    end
    clear_inputs();
  endtask

  task automatic contention();
    bit i_pend, d_pend, first_d, seen;
    for (int r = 0; r < 4; r++) begin
      i_pend = 1; d_pend = 1; seen = 0; first_d = 0;
      i_r = 1; d_r = 1; i_a = 16'h1000 + 16'(r * 16); d_a = 16'h2000 + 16'(r * 16);
      for (int c = 0; c < 40 && (i_pend || d_pend); c++) begin
        presp = m_busy && busy_cnt >= 2;
        prd = {4{$urandom()}};
        #1;
        if (!seen && pmem_read) begin
          seen = 1; first_d = (pmem_address == d_a);
        end
        check_out($sformatf("contend%0d", r));
        if (i_mem_resp === 1'b1) i_pend = 0;
        if (d_mem_resp === 1'b1) d_pend = 0;
        tick();
        i_r = i_pend; d_r = d_pend;
      end
      presp = 0;
      checks++;
      if (i_pend || d_pend || !seen) begin
        errors++;
        $display("FAIL contend%0d timeout: i_pend=%0d d_pend=%0d", r, i_pend, d_pend);
      end
      checks++;
      if (first_d !== !RR) begin
        errors++;
        $display("FAIL contend%0d first grant: got=%s want=%s", r,
                 first_d ? "D" : "I", RR ? "I" : "D");
      end else begin
        $display("contend round %0d: first grant %s", r, first_d ? "D" : "I");
      end
    end
    clear_inputs();
    step("contend_idle");
  endtask

  task automatic reset_mid_serve();
    d_r = 1; d_a = 16'h3330;
    step("rst_req");
    step("rst_serve");
    #2;
    rst = 1;
    m_busy = 0; m_last_d = 1; busy_cnt = 0;
    #1;
    checks++;
    if (dut_out() !== '0) begin
      errors++;
      $display("FAIL async_reset outputs: got=%h want=0", dut_out());
    end
    @(negedge clk);
    rst = 0; d_r = 0; presp = 1; prd = LC;
    step("late_resp");
    presp = 0;
    i_r = 1; i_a = 16'h7770;
    step("post_rst_idle");
    step("post_rst_serve");
    presp = 1; prd = LC;
    #1;
    checks++;
    if (i_mem_resp !== 1'b1 || i_mem_rdata !== LC) begin
      errors++;
      $display("FAIL post_rst_resp: resp=%b rdata=%h want resp=1 rdata=%h", i_mem_resp, i_mem_rdata, LC);
    end
    check_out("post_rst_resp");
    tick();
    clear_inputs();
    step("post_rst_done");
  endtask

  task automatic back_to_back();
    d_r = 1; d_a = 16'h0500;
    step("b2b_req");
    presp = 1; prd = L5;
    step("b2b_resp");
    presp = 0;
    #1;
    checks++;
    if (pmem_read !== 1'b0 || d_mem_resp !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: pmem_read=%b d_resp=%b want 0 0", pmem_read, d_mem_resp);
    end
    check_out("b2b_gap");
    tick();
    #1;
    checks++;
    if (pmem_read !== 1'b1 || pmem_address !== 16'h0500) begin
      errors++;
      $display("FAIL b2b_second: pmem_read=%b addr=%h want 1 0500", pmem_read, pmem_address);
    end
    check_out("b2b_second");
    tick();
    presp = 1;
    step("b2b_resp2");
    clear_inputs();
    step("b2b_done");
  endtask

  task automatic random_traffic();
    bit i_pend = 0, d_pend = 0;
    int i_iss = 0, d_iss = 0, i_got = 0, d_got = 0;
    int lat = 0;
    for (int c = 0; c < 600; c++) begin
      bit issue;
      issue = (c < 500);
      if (!issue && !i_pend && !d_pend) break;
      if (!i_pend && issue && $urandom_range(2) == 0) begin
        i_pend = 1; i_iss++;
        i_w = $urandom_range(1); i_r = i_w ? $urandom_range(1) : 1'b1;
        i_a = 16'($urandom()); i_wd = {4{$urandom()}};
      end
      if (!d_pend && issue && $urandom_range(2) == 0) begin
        d_pend = 1; d_iss++;
        d_w = $urandom_range(1); d_r = d_w ? $urandom_range(1) : 1'b1;
        d_a = 16'($urandom()); d_wd = {4{$urandom()}};
      end
      if (busy_cnt == 1) lat = $urandom_range(3) + 1;
      presp = m_busy ? (busy_cnt >= lat) : ($urandom_range(7) == 0);
      prd = {4{$urandom()}};
      #1;
      check_out("random");
      if (i_mem_resp === 1'b1) begin i_got++; i_pend = 0; end
      if (d_mem_resp === 1'b1) begin d_got++; d_pend = 0; end
      tick();
      if (!i_pend) begin i_r = 0; i_w = 0; end
      if (!d_pend) begin d_r = 0; d_w = 0; end
    end
    clear_inputs();
    checks++;
    if (i_got != i_iss || i_pend) begin
      errors++;
      $display("FAIL random_i_count: got=%0d resps want=%0d", i_got, i_iss);
    end
    checks++;
    if (d_got != d_iss || d_pend) begin
      errors++;
      $display("FAIL random_d_count: got=%0d resps want=%0d", d_got, d_iss);
    end
    $display("random traffic: I %0d/%0d D %0d/%0d", i_got, i_iss, d_got, d_iss);
  endtask

  initial begin
    // Rows are one cycle each; expected command/resp columns follow.
    tbl.push_back(mk(1, 16'h1230, 0, 0, 16'h0,    '0, 0, '0, 0, 0, 16'h0,    '0, 0, 0));
    tbl.push_back(mk(1, 16'h1230, 0, 0, 16'h0,    '0, 0, '0, 1, 0, 16'h1230, '0, 0, 0));
    tbl.push_back(mk(1, 16'h1230, 0, 0, 16'h0,    '0, 0, '0, 1, 0, 16'h1230, '0, 0, 0));
    tbl.push_back(mk(1, 16'h1230, 0, 0, 16'h0,    '0, 0, '0, 1, 0, 16'h1230, '0, 0, 0));
    tbl.push_back(mk(1, 16'h1230, 0, 0, 16'h0,    '0, 1, LA, 1, 0, 16'h1230, '0, 1, 0));
    tbl.push_back(mk(0, 16'h0,    0, 0, 16'h0,    '0, 0, '0, 0, 0, 16'h0,    '0, 0, 0));
    tbl.push_back(mk(0, 16'h0,    0, 1, 16'h4560, L5, 0, '0, 0, 0, 16'h0,    '0, 0, 0));
    tbl.push_back(mk(0, 16'h0,    0, 1, 16'h4560, L5, 0, '0, 0, 1, 16'h4560, L5, 0, 0));
    tbl.push_back(mk(0, 16'h0,    0, 1, 16'h4560, L5, 1, LC, 0, 1, 16'h4560, L5, 0, 1));
    tbl.push_back(mk(0, 16'h0,    0, 0, 16'h0,    '0, 1, LC, 0, 0, 16'h0,    '0, 0, 0));
    tbl.push_back(mk(0, 16'h0,    1, 1, 16'h0010, LC, 0, '0, 0, 0, 16'h0,    '0, 0, 0));
    tbl.push_back(mk(0, 16'h0,    1, 1, 16'h0010, LC, 0, '0, 0, 1, 16'h0010, LC, 0, 0));
    tbl.push_back(mk(0, 16'h0,    1, 1, 16'h0010, LC, 1, LA, 0, 1, 16'h0010, LC, 0, 1));
    tbl.push_back(mk(0, 16'h0,    0, 0, 16'h0,    '0, 0, '0, 0, 0, 16'h0,    '0, 0, 0));

    rst = 1;
    clear_inputs();
    d_r = 1; i_w = 1; presp = 1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dut_out() !== '0) begin
      errors++;
      $display("FAIL reset_state: got=%h want=0", dut_out());
    end
    do_reset();

    run_table();
    $display("directed table done: %0d rows", tbl.size());
    contention();
    reset_mid_serve();
    $display("reset mid-transaction sequence done");
    back_to_back();
    $display("back-to-back sequence done");
    do_reset();
    random_traffic();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 No parameters; widths fixed by lc3b_types (lc3b_word = 16 bits, lc3b_cache_line = 128 bits).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 i_mem_read  in  1  I-cache line read request, held until i_mem_resp.
REQ-005 i_mem_write  in  1  I-cache line write request, held until i_mem_resp.
REQ-006 i_mem_address  in  16  I-cache line address; bits [3:0] ignored downstream.
REQ-007 i_mem_wdata  in  128  I-cache write line.
REQ-008 i_mem_rdata  out  128  line returned to I-cache.
REQ-009 i_mem_resp  out  1  one-cycle completion pulse to I-cache.
REQ-010 d_mem_read, d_mem_write, d_mem_address, d_mem_wdata, d_mem_rdata, d_mem_resp: D-cache equivalents of REQ-004..009, same directions and widths.
REQ-011 pmem_read  out  1  line read to physical memory.
REQ-012 pmem_write  out  1  line write to physical memory.
REQ-013 pmem_address  out  16  physical address, forwarded unmodified from granted client.
REQ-014 pmem_wdata  out  128  write line from granted client.
REQ-015 pmem_rdata  in  128  line from physical memory.
REQ-016 pmem_resp  in  1  one-cycle completion pulse from physical memory.

Function
REQ-017 FSM states: IDLE, SERVE_I, SERVE_D; state register only.
REQ-018 IDLE: a pending request (read|write) latches the grant; the state moves to SERVE_I or SERVE_D on the next edge; no pmem_* command is asserted while in IDLE.
REQ-019 SERVE_x: pmem_read/pmem_write/pmem_address/pmem_wdata driven combinationally from client x; the other client sees resp=0.
REQ-020 Both read and write asserted by one client: treated as write; pmem_read held 0.
REQ-021 pmem_resp in SERVE_x: forwarded the same cycle as x_mem_resp=1 with x_mem_rdata=pmem_rdata; the FSM returns to IDLE on that edge.
REQ-022 Minimum latency: request seen at edge N, pmem command visible after edge N, client resp in the pmem_resp cycle, next grant possible no earlier than one IDLE cycle later.
REQ-023 x_mem_rdata = pmem_rdata at all times; it is only meaningful when x_mem_resp=1.
REQ-024 Client request dropped mid-transaction: the arbiter stays in SERVE_x until pmem_resp; the command outputs follow the client, so pmem sees the drop.
REQ-025 pmem_resp while in IDLE: ignored; no client resp.
REQ-026 Simultaneous I and D requests in IDLE: resolved per Configuration; the loser stays pending and is served next.
REQ-027 No request is lost or served twice; each client receives exactly one resp per held request.

Reset
REQ-028 rst asserted, at any time including mid-transaction: state=IDLE immediately (async); pmem_read=pmem_write=0, pmem_address=0, pmem_wdata=0, i_mem_resp=d_mem_resp=0.
REQ-029 Any in-flight pmem transaction is abandoned; a later pmem_resp is ignored per REQ-025.
REQ-030 The round-robin last-grant register resets to D, so I wins the first contention.

Configuration
REQ-031 Macro CACHE_ARB_ROUND_ROBIN_EN defined: on contention, grant the client not granted last; last-grant updates on every grant.
REQ-032 Macro undefined: fixed priority, D-cache always wins contention; the last-grant register is not built.

Structure
REQ-033 The arbiter state enum (lc3b_arb_state) is added to lc3b_types; widths use the existing lc3b_word and lc3b_cache_line types.
REQ-034 Sub-module cache_arbiter_control holds the FSM and grant logic; the top level holds only the output muxing, consistent with the existing control/datapath split.

Verification
REQ-035 Single I read 0x1230; pmem_resp after 3 cycles with line 0xAAAA...: i_mem_resp pulses once with that line; d_mem_resp stays 0.
REQ-036 Single D write 0x4560 with line 0x5555...: pmem_write=1, pmem_address=0x4560, pmem_wdata=0x5555...; d_mem_resp on pmem_resp.
REQ-037 I and D requesting in the same cycle, repeated 4 times: with RR_EN the grant order is I,D,I,D; without it, D is served first each time.
REQ-038 rst pulsed during SERVE_D before pmem_resp: outputs zero immediately; a late pmem_resp produces no client resp; a new I request is then served normally.
REQ-039 D read and write both asserted at 0x0010: pmem_write=1 and pmem_read=0.
REQ-040 Back-to-back D requests: an IDLE cycle separates the resp from the next pmem command, and there is no duplicate resp.
